snake_head: RTL and testbench

Movement controller that owns the snake head position and drives the 40-bit `snakehead` bus consumed by the `food` block. It converts player direction buttons into fixed-step moves at a divided tick rate, pulses `update` for each move, samples the `overlap` result returned by `food` to count score, and detects wall collisions. It sits between the button debouncers and `food`/VGA drawing logic.

---
 rtl/snake_head_pkg.sv | 50 +++++
 rtl/snake_head_tick_divider.sv | 36 +++
 rtl/snake_head.sv | 170 +++++++++++++++++
 tb/tb_snake_head.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_head_pkg.sv
// Shared definitions for the snake head controller and its neighbours.
// Holds the direction encoding, the controller state encoding, the 40-bit
// head-box packing used on the snakehead bus (also consumed by food) and
// the default screen bounds.
package snake_head_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_t;

  // Field positions of the packed head box.
  localparam int unsigned COORD_W   = 10;
  localparam int unsigned LEFT_MSB  = 39;
  localparam int unsigned LEFT_LSB  = 30;
  localparam int unsigned TOP_MSB   = 29;
  localparam int unsigned TOP_LSB   = 20;
  localparam int unsigned RIGHT_MSB = 19;
  localparam int unsigned RIGHT_LSB = 10;
  localparam int unsigned BOT_MSB   = 9;
  localparam int unsigned BOT_LSB   = 0;

  // Member order matches the field positions above.
  typedef struct packed {
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] right;
    logic [COORD_W-1:0] bottom;
  } head_t;

  // Default screen bounds (640x480).
  localparam int SCREEN_X_LO = 0;
  localparam int SCREEN_X_HI = 639;
  localparam int SCREEN_Y_LO = 0;
  localparam int SCREEN_Y_HI = 479;

  // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  function automatic dir_t reverse_of(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_head_tick_divider.sv
// Move-rate divider for the snake head.
// Counts 0..TICK_DIV-1 while en is high and pulses tick in the cycle the
// count sits at TICK_DIV-1; clr holds the count at zero.
//   clk     : system clock, rising edge
//   start_n : asynchronous active-low reset
//   en      : count enable
//   clr     : synchronous clear (wins over en)
//   tick    : one-cycle pulse once every TICK_DIV enabled cycles
module tick_divider #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic start_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/snake_head.sv
// Snake head movement controller.
// Turns debounced direction buttons into STEP-pixel moves at the divided
// tick rate, publishes the head box on snakehead with a one-cycle update
// pulse, scores food from the overlap flag returned by food, and stops in
// DEAD when a move would leave the screen.
//   clk                          : system clock, rising edge
//   start_n                      : asynchronous active-low reset
//   btn_up/down/left/right       : debounced level buttons
//   overlap                      : head covers food (from food)
//   snakehead[39:0]              : {left x, top y, right x, bottom y}
//   update                       : one-cycle pulse, new snakehead valid
//   score[7:0]                   : food eaten, saturating at 255
//   dead                         : high while in DEAD
module snake_head
  import snake_head_pkg::*;
#(
  parameter int          STEP     = 16,
  parameter int          X_LO     = SCREEN_X_LO,
  parameter int          X_HI     = SCREEN_X_HI,
  parameter int          Y_LO     = SCREEN_Y_LO,
  parameter int          Y_HI     = SCREEN_Y_HI,
  parameter int          START_X  = 320,
  parameter int          START_Y  = 240,
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic        clk,
  input  logic        start_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        overlap,
  output logic [39:0] snakehead,
  output logic        update,
  output logic [7:0]  score,
  output logic        dead
);

  localparam head_t HEAD_RST = '{
    left:   COORD_W'(START_X),
    top:    COORD_W'(START_Y),
    right:  COORD_W'(START_X + STEP - 1),
    bottom: COORD_W'(START_Y + STEP - 1)
  };

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] XLO_S  = 11'(X_LO);
  localparam logic signed [10:0] XHI_S  = 11'(X_HI);
  localparam logic signed [10:0] YLO_S  = 11'(Y_LO);
  localparam logic signed [10:0] YHI_S  = 11'(Y_HI);

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  head_t       head_q, head_d;
  logic        update_q, update_d;
  logic        update_dly_q;
  logic [7:0]  score_q;
  logic        tick;

  dir_t        req;
  logic        any_btn;

  logic signed [10:0] cur_l, cur_t;
  logic signed [10:0] nxt_l, nxt_t, nxt_r, nxt_b;
  logic               hit_wall;

  // Counter is held clear outside RUN, so it starts at zero on RUN entry.
  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .start_n (start_n),
    .en      (state_q == ST_RUN),
    .clr     (state_q != ST_RUN),
    .tick    (tick)
  );

  // Button request, priority up > down > left > right.
  always_comb begin
    req     = dir_q;
    any_btn = 1'b1;
    if (btn_up)         req = DIR_UP;
    else if (btn_down)  req = DIR_DOWN;
    else if (btn_left)  req = DIR_LEFT;
    else if (btn_right) req = DIR_RIGHT;
    else                any_btn = 1'b0;
  end

  // Candidate move from the registered direction; 11-bit signed so a step
  // past column/row 0 shows up as a negative value.
  always_comb begin
    cur_l = $signed({1'b0, head_q.left});
    cur_t = $signed({1'b0, head_q.top});
    nxt_l = cur_l;
    nxt_t = cur_t;
    case (dir_q)
      DIR_UP:    nxt_t = cur_t - STEP_S;
      DIR_DOWN:  nxt_t = cur_t + STEP_S;
      DIR_LEFT:  nxt_l = cur_l - STEP_S;
      default:   nxt_l = cur_l + STEP_S;
    endcase
    nxt_r    = nxt_l + STEP_S - 11'sd1;
    nxt_b    = nxt_t + STEP_S - 11'sd1;
    hit_wall = (nxt_l < XLO_S) || (nxt_r > XHI_S) ||
               (nxt_t < YLO_S) || (nxt_b > YHI_S);
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    head_d   = head_q;
    update_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_btn) begin
          state_d = ST_RUN;
          dir_d   = req;
        end
      end
      ST_RUN: begin
        if (any_btn && (req != reverse_of(dir_q))) dir_d = req;
        if (tick) begin
          if (hit_wall) begin
            state_d = ST_DEAD;
          end else begin
            head_d = '{
              left:   nxt_l[9:0],
              top:    nxt_t[9:0],
              right:  nxt_r[9:0],
              bottom: nxt_b[9:0]
            };
            update_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_RIGHT;
      head_q   <= HEAD_RST;
      update_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      head_q   <= head_d;
      update_q <= update_d;
    end
  end

  // overlap only counts in the cycle following an update pulse.
  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      update_dly_q <= 1'b0;
      score_q      <= '0;
    end else begin
      update_dly_q <= update_q;
      if (update_dly_q && overlap && (score_q != '1)) score_q <= score_q + 8'd1;
    end
  end

  assign snakehead = head_q;
  assign update    = update_q;
  assign score     = score_q;
  assign dead      = (state_q == ST_DEAD);

endmodule

// File: tb/tb_snake_head.sv
// Directed bench for snake_head with a 4-cycle move tick.
module tb_snake_head;

  logic        clk = 1'b0;
  logic        start_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        overlap = 1'b0;
  logic [39:0] snakehead;
  logic        update;
  logic [7:0]  score;
  logic        dead;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  btn;   // {up, down, left, right}
    logic        ov;
    int unsigned l;
    int unsigned t;
    logic        upd;
    int unsigned sc;
  } vec_t;

  vec_t vecs[$];

  snake_head #(
    .STEP     (16),
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .start_n   (start_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .overlap   (overlap),
    .snakehead (snakehead),
    .update    (update),
    .score     (score),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] box(input int unsigned l, input int unsigned t);
    return {10'(l), 10'(t), 10'(l + 15), 10'(t + 15)};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] b, input logic ov, input int unsigned l,
                     input int unsigned t, input logic upd, input int unsigned sc);
    vec_t v;
    v.btn = b; v.ov = ov; v.l = l; v.t = t; v.upd = upd; v.sc = sc;
    vecs.push_back(v);
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until update is seen; ends #1 after the pulse edge.
  task automatic wait_update(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (update) break;
    end
    chk("wait_update", {39'd0, update}, 40'd1);
  endtask

  initial begin
    int unsigned exp_sc;
    logic [3:0]  nd [4];
    nd[0] = 4'b1000; nd[1] = 4'b0001; nd[2] = 4'b0100; nd[3] = 4'b0010;

    // ---- reset and idle ----
    step(); step();
    chk("rst_head", snakehead, box(320, 240));
    chk("rst_update", {39'd0, update}, 40'd0);
    chk("rst_score", {32'd0, score}, 40'd0);
    chk("rst_dead", {39'd0, dead}, 40'd0);
    start_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_update", {39'd0, update}, 40'd0);
    end
    chk("idle_head", snakehead, box(320, 240));
    chk("idle_score", {32'd0, score}, 40'd0);

    // ---- table: start, moves, reverse reject, turns, scoring ----
    add(4'b0001, 0, 320, 240, 0, 0);
    for (int i = 0; i < 3; i++) add(4'b0000, 0, 320, 240, 0, 0);
    add(4'b0000, 0, 336, 240, 1, 0);
    for (int i = 0; i < 3; i++) add(4'b0000, 0, 336, 240, 0, 0);
    add(4'b0000, 0, 352, 240, 1, 0);
    for (int i = 0; i < 3; i++) add(4'b0010, 0, 352, 240, 0, 0);
    add(4'b0010, 0, 368, 240, 1, 0);
    add(4'b1000, 0, 368, 240, 0, 0);
    add(4'b0000, 0, 368, 240, 0, 0);
    add(4'b0000, 0, 368, 240, 0, 0);
    add(4'b0000, 0, 368, 224, 1, 0);
    add(4'b0010, 0, 368, 224, 0, 0);
    add(4'b0000, 0, 368, 224, 0, 0);
    add(4'b0000, 0, 368, 224, 0, 0);
    add(4'b0000, 0, 352, 224, 1, 0);
    add(4'b0000, 0, 352, 224, 0, 0);
    add(4'b0000, 1, 352, 224, 0, 1);
    add(4'b0000, 1, 352, 224, 0, 1);
    add(4'b0000, 1, 336, 224, 1, 1);
    add(4'b0000, 1, 336, 224, 0, 1);
    add(4'b0000, 1, 336, 224, 0, 2);
    add(4'b0000, 1, 336, 224, 0, 2);
    add(4'b0000, 0, 320, 224, 1, 2);
    add(4'b0000, 0, 320, 224, 0, 2);
    add(4'b0000, 1, 320, 224, 0, 3);
    add(4'b0000, 0, 320, 224, 0, 3);

    foreach (vecs[i]) begin
      set_btn(vecs[i].btn);
      overlap = vecs[i].ov;
      step();
      chk($sformatf("vec%0d_head", i), snakehead, box(vecs[i].l, vecs[i].t));
      chk($sformatf("vec%0d_update", i), {39'd0, update}, {39'd0, vecs[i].upd});
      chk($sformatf("vec%0d_score", i), {32'd0, score}, 40'(vecs[i].sc));
      chk($sformatf("vec%0d_dead", i), {39'd0, dead}, 40'd0);
    end
    set_btn(4'b0000);
    overlap = 1'b0;

    // ---- score saturation: walk a square, hit food after every move ----
    exp_sc = 3;
    for (int n = 0; n < 253; n++) begin
      wait_update(8);
      step();
      overlap = 1'b1;
      set_btn(nd[n % 4]);
      step();
      overlap = 1'b0;
      set_btn(4'b0000);
      if (exp_sc < 255) exp_sc++;
      chk("score_walk", {32'd0, score}, 40'(exp_sc));
    end
    chk("score_sat", {32'd0, score}, 40'd255);
    chk("sat_alive", {39'd0, dead}, 40'd0);

    // ---- reset two cycles before a tick ----
    start_n = 1'b0;
    #1;
    chk("mid_rst_head", snakehead, box(320, 240));
    chk("mid_rst_update", {39'd0, update}, 40'd0);
    chk("mid_rst_score", {32'd0, score}, 40'd0);
    chk("mid_rst_dead", {39'd0, dead}, 40'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_hold_update", {39'd0, update}, 40'd0);
    end
    start_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_idle_update", {39'd0, update}, 40'd0);
    end
    chk("post_rst_idle_head", snakehead, box(320, 240));

    // ---- run up into the top wall ----
    set_btn(4'b1000);
    step();
    set_btn(4'b0000);
    for (int k = 1; k <= 15; k++) begin
      wait_update(8);
      chk($sformatf("up%0d_head", k), snakehead, box(320, 240 - 16 * k));
    end
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("wall_update", {39'd0, update}, 40'd0);
      chk("wall_dead", {39'd0, dead}, (e == 4) ? 40'd1 : 40'd0);
    end
    chk("wall_head", snakehead, box(320, 0));
    for (int i = 0; i < 12; i++) begin
      set_btn(nd[i % 4]);
      step();
      chk("dead_frozen_update", {39'd0, update}, 40'd0);
    end
    set_btn(4'b0000);
    chk("dead_frozen_head", snakehead, box(320, 0));
    chk("dead_frozen_dead", {39'd0, dead}, 40'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
